// File: rtl/count_seq_if.sv
// Bundle for the counter-stream monitor: sampled stream inputs plus status outputs.
interface count_seq_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 sample_valid;
  logic [WIDTH-1:0]     count_in;
  logic                 clear;
  logic                 locked;
  logic                 mismatch;
  logic                 wrap_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WIDTH-1:0]     expected;

  modport master (
    output sample_valid, count_in, clear,
    input  locked, mismatch, wrap_pulse, err_count, expected
  );

  modport slave (
    input  sample_valid, count_in, clear,
    output locked, mismatch, wrap_pulse, err_count, expected
  );
endinterface

// File: rtl/count_sequence_checker.sv
// Monitors a mod-(WRAP_VAL+1) counter stream: predicts successors, locks after
// LOCK_CNT consecutive hits, and flags skips / out-of-range values.
//
// state  | meaning
// SEARCH | seeding or counting consecutive correct successors toward lock
// LOCKED | stream tracking its predicted sequence; any miss is flagged
module count_sequence_checker #(
  parameter int WIDTH     = 4,
  parameter int WRAP_VAL  = 14,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  count_seq_if.slave   bus
);
  localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] WRAP   = WIDTH'(WRAP_VAL);
  localparam logic [RUN_W:0]   LOCK_L = (RUN_W + 1)'(LOCK_CNT);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state, state_n;
  logic                 seeded, seeded_n;
  logic [RUN_W-1:0]     run, run_n;
  logic [WIDTH-1:0]     expected, expected_n;
  logic                 mismatch, mismatch_n;
  logic                 wrap_pulse, wrap_n;
  logic [ERR_CNT_W-1:0] err_count, err_count_n;

  logic             out_of_range;
  logic             hit;
  logic             err_inc;
  logic [WIDTH-1:0] succ;

  assign out_of_range = bus.count_in > WRAP;
  assign hit          = bus.count_in == expected;
  assign succ         = (bus.count_in == WRAP) ? '0 : bus.count_in + WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      seeded     <= 1'b0;
      run        <= '0;
      expected   <= '0;
      mismatch   <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      seeded     <= seeded_n;
      run        <= run_n;
      expected   <= expected_n;
      mismatch   <= mismatch_n;
      wrap_pulse <= wrap_n;
      err_count  <= err_count_n;
    end
  end

  always_comb begin
    state_n    = state;
    seeded_n   = seeded;
    run_n      = run;
    expected_n = expected;
    mismatch_n = 1'b0;
    wrap_n     = 1'b0;
    err_inc    = 1'b0;
    if (bus.clear) begin
      state_n  = SEARCH;
      seeded_n = 1'b0;
      run_n    = '0;
    end else if (bus.sample_valid) begin
      case (state)
        SEARCH: begin
          if (out_of_range) begin
            mismatch_n = 1'b1;
            err_inc    = 1'b1;
            seeded_n   = 1'b0;
            run_n      = '0;
          end else if (!seeded) begin
            expected_n = succ;
            seeded_n   = 1'b1;
            run_n      = '0;
          end else if (hit) begin
            expected_n = succ;
            if (({1'b0, run} + (RUN_W + 1)'(1)) == LOCK_L) begin
              state_n = LOCKED;
              run_n   = '0;
            end else begin
              run_n = run + RUN_W'(1);
            end
          end else begin
            // in-range skip while searching just restarts the run
            expected_n = succ;
            run_n      = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            expected_n = succ;
            wrap_n     = (bus.count_in == '0);
          end else begin
            mismatch_n = 1'b1;
            err_inc    = 1'b1;
            state_n    = SEARCH;
            run_n      = '0;
            if (out_of_range) seeded_n = 1'b0;
            else              expected_n = succ;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_comb begin
    err_count_n = err_count;
    if (bus.clear)                     err_count_n = '0;
    else if (err_inc && !(&err_count)) err_count_n = err_count + ERR_CNT_W'(1);
  end

  assign bus.locked     = (state == LOCKED);
  assign bus.mismatch   = mismatch;
  assign bus.wrap_pulse = wrap_pulse;
  assign bus.err_count  = err_count;
  assign bus.expected   = expected;
endmodule
